uart_frame_tx: RTL and testbench

Transmit-side framer for the UART command link. It builds a response frame (start byte, length, command, payload pulled from the result FIFO, end byte) and feeds it one byte at a time to the UART transmitter through a send/ready handshake. It sits between the matrix/vector result FIFO and the UART TX serializer, and is launched by the command controller when a reply is due.

---
 rtl/uart_frame_tx_if.sv | 28 ++
 rtl/uart_frame_tx.sv | 127 ++++++++++++
 tb/tb_uart_frame_tx.sv | 397 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_frame_tx_if.sv
// Handshake bundle between the command controller / result FIFO / UART TX
// and the response framer.
interface uart_frame_tx_if;
  logic       start;
  logic [7:0] cmd;
  logic [7:0] length;
  logic [7:0] fifo_data;
  logic       fifo_empty;
  logic       fifo_pop;
  logic       Tx_ready;
  logic [7:0] tx_data;
  logic       tx_send;
  logic       busy;
  logic       done;
  logic       error;

  // master: the surrounding system (controller, FIFO, UART TX)
  modport master (
    output start, cmd, length, fifo_data, fifo_empty, Tx_ready,
    input  fifo_pop, tx_data, tx_send, busy, done, error
  );

  // slave: the framer itself
  modport slave (
    input  start, cmd, length, fifo_data, fifo_empty, Tx_ready,
    output fifo_pop, tx_data, tx_send, busy, done, error
  );
endinterface

// File: rtl/uart_frame_tx.sv
// Response framer: START, length, cmd, payload from result FIFO, END,
// handed one byte at a time to the UART TX via send/ready pulses.
module uart_frame_tx #(
  parameter logic [7:0] START_BYTE = 8'hFE,
  parameter logic [7:0] END_BYTE   = 8'hEF,
  parameter int         TIMEOUT    = 16
) (
  input  logic clk,
  input  logic reset,
  uart_frame_tx_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, WAIT} state_t;
  typedef enum logic [2:0] {HDR_FE, HDR_LEN, HDR_CMD, PAYLOAD, TRAILER} field_t;

  state_t          state_q, state_d;
  field_t          field_q, field_d;
  logic [7:0]      cmd_q, cmd_d;
  logic [7:0]      len_q, len_d;
  logic [7:0]      rem_q, rem_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [7:0]      txd_q, txd_d;
  logic            err_q, err_d;
  logic            done_q, done_d;
  logic            pop_c;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      field_q <= HDR_FE;
      cmd_q   <= '0;
      len_q   <= '0;
      rem_q   <= '0;
      tmo_q   <= '0;
      txd_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      field_q <= field_d;
      cmd_q   <= cmd_d;
      len_q   <= len_d;
      rem_q   <= rem_d;
      tmo_q   <= tmo_d;
      txd_q   <= txd_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    field_d = field_q;
    cmd_d   = cmd_q;
    len_d   = len_q;
    rem_d   = rem_q;
    tmo_d   = tmo_q;
    txd_d   = txd_q;
    err_d   = err_q;
    done_d  = 1'b0;
    pop_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          cmd_d   = bus.cmd;
          len_d   = bus.length;
          rem_d   = bus.length;
          tmo_d   = '0;
          err_d   = 1'b0;
          field_d = HDR_FE;
          state_d = LOAD;
        end
      end
      LOAD: begin
        state_d = SEND;
        case (field_q)
          HDR_FE:  txd_d = START_BYTE;
          HDR_LEN: txd_d = len_q;
          HDR_CMD: txd_d = cmd_q;
          PAYLOAD: begin
            // error was raised on the previous cycle; abandon the payload now
            if (tmo_q == TW'(TIMEOUT)) begin
              txd_d   = END_BYTE;
              field_d = TRAILER;
              rem_d   = '0;
              tmo_d   = '0;
            end else if (!bus.fifo_empty) begin
              txd_d = bus.fifo_data;
              pop_c = 1'b1;
              rem_d = rem_q - 8'd1;
              tmo_d = '0;
            end else begin
              state_d = LOAD;
              tmo_d   = tmo_q + TW'(1);
              if (tmo_q == TW'(TIMEOUT - 1)) err_d = 1'b1;
            end
          end
          default: txd_d = END_BYTE;
        endcase
      end
      SEND: state_d = WAIT;
      WAIT: begin
        if (bus.Tx_ready) begin
          state_d = LOAD;
          case (field_q)
            HDR_FE:  field_d = HDR_LEN;
            HDR_LEN: field_d = HDR_CMD;
            HDR_CMD, PAYLOAD: field_d = (rem_q != 8'd0) ? PAYLOAD : TRAILER;
            default: begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.tx_data  = txd_q;
  assign bus.tx_send  = (state_q == SEND);
  assign bus.fifo_pop = pop_c;
  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = done_q;
  assign bus.error    = err_q;
endmodule

// File: tb/tb_uart_frame_tx.sv
// Scoreboard bench for uart_frame_tx: FIFO model, UART ready responder,
// byte/timing checks per scenario.
module tb_uart_frame_tx;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  uart_frame_tx_if bus();
  uart_frame_tx #(.START_BYTE(8'hFE), .END_BYTE(8'hEF), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int tests = 0, fails = 0, cyc = 0;
  int nsend = 0, npop = 0, ndone = 0, done_cyc = -1, err_cyc = -1, start_cyc = 0;
  int resp_dly = 10;
  logic [7:0] exp_q[$], got_q[$], fifo_q[$];
  int sc_q[$];
  logic rdy_r = 1'b0, spur_rdy = 1'b0, prev_err = 1'b0;
  logic [7:0] fd_r = 8'h00;
  logic fe_r = 1'b1;

  assign bus.Tx_ready   = rdy_r | spur_rdy;
  assign bus.fifo_data  = fd_r;
  assign bus.fifo_empty = fe_r;

  always @(posedge clk) cyc++;

  // first-word-fall-through FIFO; a pop seen mid-cycle retires the head after the edge
  always begin : fifo_model
    logic p;
    @(negedge clk);
    p = bus.fifo_pop;
    @(posedge clk);
    #1;
    if (p && fifo_q.size() > 0) void'(fifo_q.pop_front());
    fe_r = (fifo_q.size() == 0);
    fd_r = fe_r ? 8'h00 : fifo_q[0];
  end

  always @(negedge clk) begin
    if (bus.tx_send) begin
      got_q.push_back(bus.tx_data);
      sc_q.push_back(cyc);
      nsend++;
    end
    if (bus.fifo_pop) npop++;
    if (bus.done) begin
      ndone++;
      done_cyc = cyc;
    end
    if (bus.error && !prev_err) err_cyc = cyc;
    prev_err = bus.error;
  end

  // UART TX model: Tx_ready lands resp_dly cycles after each tx_send
  always begin
    @(negedge clk);
    if (bus.tx_send) begin
      repeat (resp_dly) @(negedge clk);
      rdy_r = 1'b1;
      @(negedge clk);
      rdy_r = 1'b0;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [7:0] c, input logic [7:0] l);
    bus.start  = 1'b1;
    bus.cmd    = c;
    bus.length = l;
    start_cyc  = cyc;
    tick();
    bus.start  = 1'b0;
  endtask

  task automatic wait_done(input int n, input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      tick();
      if (ndone >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_sends(input int n, input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      tick();
      if (nsend >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    #2;
    reset = 1'b0;
    repeat (2) tick();
    tests++;
    if ({bus.tx_data, bus.tx_send, bus.fifo_pop, bus.busy, bus.done, bus.error} !== 13'h0) begin
      fails++;
      $display("FAIL reset_outputs got=%h exp=0",
               {bus.tx_data, bus.tx_send, bus.fifo_pop, bus.busy, bus.done, bus.error});
    end
    reset = 1'b1;
    repeat (3) tick();
    tests++;
    if (nsend != 0 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle got sends=%0d busy=%b exp 0 0", nsend, bus.busy);
    end
  endtask

  task automatic test_basic;
    bit ok;
    int p0, d0;
    logic [7:0] e, g;
    resp_dly = 10;
    got_q.delete(); sc_q.delete();
    p0 = npop; d0 = ndone;
    fifo_q.push_back(8'h11); fifo_q.push_back(8'h22); fifo_q.push_back(8'h33);
    exp_q = '{8'hFE, 8'h03, 8'h02, 8'h11, 8'h22, 8'h33, 8'hEF};
    tick();
    start_frame(8'h02, 8'd3);
    wait_done(d0 + 1, 300, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL basic_done got=timeout exp=done"); end
    tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b1) begin
      fails++;
      $display("FAIL basic_busy_done got busy=%b done=%b exp 0 1", bus.busy, bus.done);
    end
    tests++;
    if (sc_q.size() == 0 || sc_q[0] != start_cyc + 2) begin
      fails++;
      $display("FAIL basic_first_send got=%0d exp=%0d", sc_q.size() ? sc_q[0] : -1, start_cyc + 2);
    end
    for (int i = 1; i < sc_q.size(); i++) begin
      tests++;
      if (sc_q[i] - sc_q[i-1] != 12) begin
        fails++;
        $display("FAIL basic_gap%0d got=%0d exp=12", i, sc_q[i] - sc_q[i-1]);
      end
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); tests++;
      if (got_q.size() == 0) begin fails++; $display("FAIL basic_byte got=none exp=%h", e); end
      else begin
        g = got_q.pop_front();
        if (g !== e) begin fails++; $display("FAIL basic_byte got=%h exp=%h", g, e); end
      end
    end
    tests++;
    if (got_q.size() != 0) begin fails++; $display("FAIL basic_extra got=%0d exp=0", got_q.size()); end
    tests++;
    if (npop - p0 != 3) begin fails++; $display("FAIL basic_pops got=%0d exp=3", npop - p0); end
    tests++;
    if (bus.error !== 1'b0) begin fails++; $display("FAIL basic_error got=%b exp=0", bus.error); end
    repeat (3) tick();
    tests++;
    if (ndone - d0 != 1) begin fails++; $display("FAIL basic_done_count got=%0d exp=1", ndone - d0); end
  endtask

  task automatic test_len0;
    bit ok;
    int p0, d0;
    logic [7:0] e, g;
    resp_dly = 3;
    got_q.delete(); sc_q.delete();
    p0 = npop; d0 = ndone;
    exp_q = '{8'hFE, 8'h00, 8'h01, 8'hEF};
    start_frame(8'h01, 8'd0);
    wait_done(d0 + 1, 200, ok);
    tests++;
    if (!ok || sc_q.size() != 4 || done_cyc != sc_q[3] + 4) begin
      fails++;
      $display("FAIL len0_done_time got=%0d exp=%0d", done_cyc, sc_q.size() == 4 ? sc_q[3] + 4 : -1);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); tests++;
      if (got_q.size() == 0) begin fails++; $display("FAIL len0_byte got=none exp=%h", e); end
      else begin
        g = got_q.pop_front();
        if (g !== e) begin fails++; $display("FAIL len0_byte got=%h exp=%h", g, e); end
      end
    end
    tests++;
    if (npop != p0) begin fails++; $display("FAIL len0_pops got=%0d exp=0", npop - p0); end
  endtask

  task automatic test_underrun;
    bit ok;
    int p0, d0, s3, s4;
    logic [7:0] e, g;
    resp_dly = 10;
    got_q.delete(); sc_q.delete();
    p0 = npop; d0 = ndone; err_cyc = -1;
    fifo_q.push_back(8'hAA);
    exp_q = '{8'hFE, 8'h02, 8'h03, 8'hAA, 8'hEF};
    tick();
    start_frame(8'h03, 8'd2);
    wait_done(d0 + 1, 300, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL under_done got=timeout exp=done"); end
    s3 = (sc_q.size() > 4) ? sc_q[3] : -100;
    s4 = (sc_q.size() > 4) ? sc_q[4] : -100;
    tests++;
    if (err_cyc != s3 + 10 + 1 + 8) begin
      fails++;
      $display("FAIL under_err_time got=%0d exp=%0d", err_cyc, s3 + 19);
    end
    tests++;
    if (s4 != err_cyc + 1) begin fails++; $display("FAIL under_end_time got=%0d exp=%0d", s4, err_cyc + 1); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); tests++;
      if (got_q.size() == 0) begin fails++; $display("FAIL under_byte got=none exp=%h", e); end
      else begin
        g = got_q.pop_front();
        if (g !== e) begin fails++; $display("FAIL under_byte got=%h exp=%h", g, e); end
      end
    end
    tests++;
    if (npop - p0 != 1) begin fails++; $display("FAIL under_pops got=%0d exp=1", npop - p0); end
    repeat (2) tick();
    tests++;
    if (bus.error !== 1'b1) begin fails++; $display("FAIL under_sticky got=%b exp=1", bus.error); end
    got_q.delete(); sc_q.delete();
    d0 = ndone;
    start_frame(8'h04, 8'd0);
    tests++;
    if (bus.error !== 1'b0) begin fails++; $display("FAIL under_clear got=%b exp=0", bus.error); end
    wait_done(d0 + 1, 200, ok);
    tests++;
    if (!ok || bus.error !== 1'b0 || got_q.size() != 4) begin
      fails++;
      $display("FAIL under_next got ok=%b err=%b bytes=%0d exp 1 0 4", ok, bus.error, got_q.size());
    end
  endtask

  task automatic test_spurious;
    bit ok;
    int p0, d0, b0;
    logic [7:0] e, g;
    resp_dly = 10;
    got_q.delete(); sc_q.delete();
    p0 = npop; d0 = ndone; b0 = nsend;
    exp_q = '{8'hFE, 8'h02, 8'h5A, 8'h31, 8'h32, 8'hEF};
    start_frame(8'h5A, 8'd2);
    wait_sends(b0 + 3, 200, ok);
    // payload LOAD is starved here; poke start and Tx_ready into it
    repeat (12) tick();
    bus.start = 1'b1; bus.cmd = 8'h77; bus.length = 8'd9; spur_rdy = 1'b1;
    tick();
    bus.start = 1'b0; spur_rdy = 1'b0;
    fifo_q.push_back(8'h31); fifo_q.push_back(8'h32);
    wait_sends(b0 + 4, 200, ok);
    bus.start = 1'b1; spur_rdy = 1'b1;
    tick();
    bus.start = 1'b0; spur_rdy = 1'b0;
    wait_done(d0 + 1, 300, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL spur_done got=timeout exp=done"); end
    tests++;
    if (sc_q.size() < 5 || sc_q[4] - sc_q[3] != 12) begin
      fails++;
      $display("FAIL spur_gap got=%0d exp=12", sc_q.size() >= 5 ? sc_q[4] - sc_q[3] : -1);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); tests++;
      if (got_q.size() == 0) begin fails++; $display("FAIL spur_byte got=none exp=%h", e); end
      else begin
        g = got_q.pop_front();
        if (g !== e) begin fails++; $display("FAIL spur_byte got=%h exp=%h", g, e); end
      end
    end
    repeat (15) tick();
    tests++;
    if (nsend - b0 != 6 || npop - p0 != 2 || ndone - d0 != 1) begin
      fails++;
      $display("FAIL spur_counts got sends=%0d pops=%0d dones=%0d exp 6 2 1",
               nsend - b0, npop - p0, ndone - d0);
    end
  endtask

  task automatic test_reset_midframe;
    bit ok;
    int n1, p1, d0;
    logic [7:0] e, g;
    resp_dly = 10;
    fifo_q.push_back(8'h41); fifo_q.push_back(8'h42); fifo_q.push_back(8'h43);
    tick();
    start_frame(8'h07, 8'd3);
    wait_sends(nsend + 5, 300, ok);
    repeat (3) tick();
    reset = 1'b0;
    #1;
    tests++;
    if ({bus.tx_data, bus.tx_send, bus.fifo_pop, bus.busy, bus.done, bus.error} !== 13'h0) begin
      fails++;
      $display("FAIL rst_mid_outputs got=%h exp=0",
               {bus.tx_data, bus.tx_send, bus.fifo_pop, bus.busy, bus.done, bus.error});
    end
    n1 = nsend; p1 = npop;
    repeat (3) tick();
    reset = 1'b1;
    fifo_q.delete();
    repeat (14) tick();
    tests++;
    if (nsend != n1 || npop != p1 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_quiet got sends=%0d pops=%0d busy=%b exp 0 0 0", nsend - n1, npop - p1, bus.busy);
    end
    got_q.delete(); sc_q.delete();
    d0 = ndone;
    fifo_q.push_back(8'h51);
    exp_q = '{8'hFE, 8'h01, 8'h08, 8'h51, 8'hEF};
    tick();
    start_frame(8'h08, 8'd1);
    wait_done(d0 + 1, 300, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL rst_mid_done got=timeout exp=done"); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); tests++;
      if (got_q.size() == 0) begin fails++; $display("FAIL rst_mid_byte got=none exp=%h", e); end
      else begin
        g = got_q.pop_front();
        if (g !== e) begin fails++; $display("FAIL rst_mid_byte got=%h exp=%h", g, e); end
      end
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    int p0, d0, b0, d1;
    logic [7:0] e, g;
    resp_dly = 4;
    got_q.delete(); sc_q.delete();
    p0 = npop; d0 = ndone; b0 = nsend;
    fifo_q.push_back(8'h61); fifo_q.push_back(8'h62);
    exp_q = '{8'hFE, 8'h01, 8'h09, 8'h61, 8'hEF, 8'hFE, 8'h01, 8'h09, 8'h62, 8'hEF};
    tick();
    bus.start = 1'b1; bus.cmd = 8'h09; bus.length = 8'd1;
    wait_sends(b0 + 6, 300, ok);
    bus.start = 1'b0;
    d1 = done_cyc;
    tests++;
    if (!ok || ndone - d0 != 1 || sc_q.size() < 6 || sc_q[5] != d1 + 2) begin
      fails++;
      $display("FAIL b2b_restart got=%0d exp=%0d", sc_q.size() >= 6 ? sc_q[5] : -1, d1 + 2);
    end
    wait_done(d0 + 2, 300, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL b2b_done got=timeout exp=done"); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); tests++;
      if (got_q.size() == 0) begin fails++; $display("FAIL b2b_byte got=none exp=%h", e); end
      else begin
        g = got_q.pop_front();
        if (g !== e) begin fails++; $display("FAIL b2b_byte got=%h exp=%h", g, e); end
      end
    end
    repeat (10) tick();
    tests++;
    if (npop - p0 != 2 || nsend - b0 != 10) begin
      fails++;
      $display("FAIL b2b_counts got pops=%0d sends=%0d exp 2 10", npop - p0, nsend - b0);
    end
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.cmd    = 8'h00;
    bus.length = 8'h00;
    test_reset();
    test_basic();
    test_len0();
    test_underrun();
    test_spurious();
    test_reset_midframe();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
